// File: rtl/cla_pkg.sv
// Shared sizing and types for the two-level carry-lookahead adder.
package cla_pkg;

   localparam int CLA_WIDTH = 32;
   localparam int CLA_GRP   = 4;
   localparam int CLA_NGRP  = CLA_WIDTH / CLA_GRP;

   typedef logic [CLA_WIDTH-1:0] cla_word_t;

   // Carry-out plus sum, packed as one value, for callers that want a WIDTH+1 result.
   typedef logic [CLA_WIDTH:0] cla_wide_t;

endpackage

// File: rtl/cla_grp.sv
// First-level lookahead block: GRP-bit sum from a group carry-in, plus group generate/propagate.
// Group G/P do not depend on c_i, so the second level can resolve all group carries in parallel.
module cla_grp
   import cla_pkg::*;
#(
   parameter int GRP = CLA_GRP
) (
   input  logic [GRP-1:0] a_i,
   input  logic [GRP-1:0] b_i,
   input  logic           c_i,
   output logic [GRP-1:0] s_o,
   output logic           g_o,
   output logic           p_o
);

   logic [GRP-1:0] g;
   logic [GRP-1:0] p;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   always_comb begin
      logic cc;
      cc  = c_i;
      s_o = '0;
      for (int j = 0; j < GRP; j++) begin
         s_o[j] = p[j] ^ cc;
         cc     = g[j] | (p[j] & cc);
      end
   end

   always_comb begin
      logic gg;
      gg = 1'b0;
      for (int j = 0; j < GRP; j++) begin
         gg = g[j] | (p[j] & gg);
      end
      g_o = gg;
      p_o = &p;
   end

endmodule

// File: rtl/cla_adder.sv
// 32-bit two-level carry-lookahead adder with registered sum/carry and a travelling valid.
// Define CLA_IN_REG_EN to add an unconditional input register stage (latency 2 instead of 1).
module cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GRP   = CLA_GRP
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_vld,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c,
   output logic             o_vld,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c
);

   localparam int NGRP = WIDTH / GRP;

   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic             core_c;
   logic             core_vld;

`ifdef CLA_IN_REG_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   logic             vld_in_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         vld_in_q <= 1'b0;
      end else begin
         a_q      <= i_a;
         b_q      <= i_b;
         c_q      <= i_c;
         vld_in_q <= i_vld;
      end
   end

   assign core_a   = a_q;
   assign core_b   = b_q;
   assign core_c   = c_q;
   assign core_vld = vld_in_q;
`else
   assign core_a   = i_a;
   assign core_b   = i_b;
   assign core_c   = i_c;
   assign core_vld = i_vld;
`endif

   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP:0]    grp_c;
   logic [WIDTH-1:0] sum;

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_grp #(.GRP(GRP)) u_grp (
         .a_i (core_a[k*GRP +: GRP]),
         .b_i (core_b[k*GRP +: GRP]),
         .c_i (grp_c[k]),
         .s_o (sum[k*GRP +: GRP]),
         .g_o (grp_g[k]),
         .p_o (grp_p[k])
      );
   end

   // Each group carry is a flat sum-of-products of G/P terms and the carry-in,
   // so no carry waits on another group's carry.
   always_comb begin
      logic acc;
      logic pp;
      grp_c    = '0;
      grp_c[0] = core_c;
      for (int k = 0; k < NGRP; k++) begin
         acc = grp_g[k];
         pp  = grp_p[k];
         for (int j = k - 1; j >= 0; j--) begin
            acc = acc | (pp & grp_g[j]);
            pp  = pp & grp_p[j];
         end
         grp_c[k+1] = acc | (pp & core_c);
      end
   end

   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             vld_q, vld_d;

   always_comb begin
      s_d   = s_q;
      c_d   = c_q;
      vld_d = core_vld;
      if (core_vld) begin
         s_d = sum;
         c_d = grp_c[NGRP];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s_q   <= '0;
         c_q   <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         s_q   <= s_d;
         c_q   <= c_d;
         vld_q <= vld_d;
      end
   end

   assign o_s   = s_q;
   assign o_c   = c_q;
   assign o_vld = vld_q;

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: expected {carry,sum} queued at issue, popped whenever o_vld is seen.
module tb_cla_adder;
   import cla_pkg::*;

   logic      i_clk;
   logic      i_rst;
   logic      i_vld;
   cla_word_t i_a;
   cla_word_t i_b;
   logic      i_c;
   logic      o_vld;
   cla_word_t o_s;
   logic      o_c;

   cla_adder dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_vld (i_vld),
      .i_a   (i_a),
      .i_b   (i_b),
      .i_c   (i_c),
      .o_vld (o_vld),
      .o_s   (o_s),
      .o_c   (o_c)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   cla_wide_t sb[$];
   cla_wide_t last_out;
   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input cla_wide_t act, input cla_wide_t exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the capture edge.
   initial begin
      last_out = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            chk("reset_out", {o_vld, o_c, o_s}, '0);
            last_out = '0;
         end else if (o_vld) begin
            if (sb.size() == 0) begin
               chk("unexpected_vld", {1'b0, o_vld}, '0);
            end else begin
               cla_wide_t e;
               e = sb.pop_front();
               chk("result", {o_c, o_s}, e);
               last_out = e;
            end
         end else begin
            chk("hold", {o_c, o_s}, last_out);
         end
      end
   end

   task automatic drive(input logic v, input cla_word_t a, input cla_word_t b,
                        input logic c, input cla_wide_t exp);
      @(posedge i_clk);
      #1;
      i_vld = v;
      i_a   = a;
      i_b   = b;
      i_c   = c;
      if (v) sb.push_back(exp);
   endtask

   initial begin
      cla_word_t ra, rb;
      logic      rc, rv;
      i_rst = 1'b1;
      i_vld = 1'b0;
      i_a   = '0;
      i_b   = '0;
      i_c   = 1'b0;
      repeat (3) @(posedge i_clk);
      #3 i_rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);

      // Directed vectors, expected values computed by hand.
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
      drive(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
      drive(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, '0);
      drive(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, '0);
      drive(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, '0);
      drive(1'b1, 32'h0000_000F, 32'h0000_0001, 1'b0, 33'h0_0000_0010);
      drive(1'b1, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_1000_0000);
      drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
      drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
      drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 33'h1_0000_0000);
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);

      // Mid-cycle asynchronous reset with a result in flight.
      drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002);
      #2 i_rst = 1'b1;
      sb.delete();
      #1;
      chk("async_rst_s", {1'b0, o_s}, '0);
      chk("async_rst_cv", {31'b0, o_vld, o_c}, '0);
      repeat (2) @(posedge i_clk);
      #3 i_rst = 1'b0;
      i_vld = 1'b0;
      drive(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, '0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);

      // Random vectors against a WIDTH+1-bit reference add.
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1));
         drive(rv, ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {32'b0, rc});
      end

      drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge i_clk);
      @(negedge i_clk);
      #1;
      chk("drain", {1'b0, 32'(sb.size())}, '0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- 32-bit two-level carry-lookahead adder: computes {o_c, o_s} = i_a + i_b + i_c.
- Combinational CLA core followed by an output register stage (1-cycle latency), with a valid flag travelling alongside the data.
- Datapath arithmetic primitive used by ALU/accumulator blocks; no stall or backpressure.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of GRP.
- GRP, 4, bits per first-level lookahead group; WIDTH/GRP groups feed the second-level lookahead unit.

Ports:
- i_clk  input  1  clock, rising-edge active
- i_rst  input  1  asynchronous, active-high reset
- i_vld  input  1  operands valid this cycle
- i_a  input  WIDTH  operand A, unsigned
- i_b  input  WIDTH  operand B, unsigned
- i_c  input  1  carry-in
- o_vld  output  1  o_s/o_c hold a new result
- o_s  output  WIDTH  sum, registered
- o_c  output  1  carry-out, registered

Behaviour:
- Reset (i_rst=1, asynchronous, no clock needed): o_s=0, o_c=0, o_vld=0. Registers are held at these values while reset is asserted.
- Core is purely combinational, per bit:
  - g[i]=a[i]&b[i], p[i]=a[i]^b[i].
  - Group lookahead gives group generate G and group propagate P.
  - Second level: C[k+1]=G[k] | P[k]&C[k], with C[0]=i_c.
  - In-group carries come from each group's carry-in. s[i]=p[i]^c[i].
  - o_c is the carry out of the top group.
  - No ripple chain longer than GRP bits is allowed.
- Latency is 1 cycle. On the rising edge with i_vld=1: o_s and o_c take the result of the current i_a/i_b/i_c, and o_vld becomes 1.
- On an edge with i_vld=0: o_vld becomes 0, and o_s/o_c hold their previous values.
- Throughput is one result per cycle. Back-to-back i_vld pulses produce back-to-back o_vld pulses.
- Arithmetic is unsigned, modulo 2^WIDTH, and the carry is exact for all 2^(2·WIDTH+1) input combinations. No overflow flag; signed overflow is the caller's concern.
- Reset mid-operation: an in-flight result is discarded. o_vld=0 on the first edge after release, unless i_vld=1 on that edge.
- X on operands while i_vld=0 must not corrupt the held outputs.

Optional Feature:
- Macro: CLA_IN_REG_EN.
- Defined:
  - i_a, i_b, i_c and i_vld are registered first; latency becomes 2 cycles.
  - Input registers reset to 0 and capture unconditionally every cycle.
  - The output stage then applies the i_vld rules above to the registered valid.
- Undefined: inputs feed the core directly; latency is 1.

Decomposition:
- Shared package cla_pkg:
  - CLA_WIDTH=32, CLA_GRP=4, CLA_NGRP=CLA_WIDTH/CLA_GRP.
  - Typedef for the WIDTH-bit operand.
- Sub-module cla_grp:
  - GRP-bit lookahead block with inputs a, b and carry-in.
  - Outputs sum bits, group generate G and group propagate P.
  - Instantiated WIDTH/GRP times by a generate loop.
- Second-level carry unit and register stage live in cla_adder.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle -> o_s=0, o_c=0, o_vld=0 immediately; all stay 0 until i_vld is asserted after release.
- Carry through all groups: i_a=0xFFFFFFFF, i_b=0, i_c=1, i_vld=1 -> next edge o_s=0x00000000, o_c=1, o_vld=1.
- No carry: i_a=0x12345678, i_b=0x87654321, i_c=0 -> o_s=0x99999999, o_c=0. Then i_a=0x7FFFFFFF, i_b=1, i_c=0 -> o_s=0x80000000, o_c=0 on the following edge (back-to-back, o_vld stays 1).
- Maximum sum: i_a=i_b=0xFFFFFFFF, i_c=1 -> o_s=0xFFFFFFFF, o_c=1. Then drive i_vld=0 with i_a=0 -> o_vld=0 and o_s/o_c hold 0xFFFFFFFF/1.
- Random: at least 10k random (i_a, i_b, i_c) vectors with random i_vld, compared against a WIDTH+1-bit reference sum delayed by the latency. Repeat the run with CLA_IN_REG_EN defined, expecting 2-cycle latency.
- Group-boundary carries: i_a=0x0000000F, i_b=1, i_c=0 -> o_s=0x00000010. Also i_a=0x0FFFFFFF, i_b=0x00000001 -> o_s=0x10000000, o_c=0.
